// File: rtl/fetch_prefetch_unit_if.sv
// Fetch unit bus bundle: WriteBack redirect, instruction-memory
// request/grant/response channel, Decode valid/ready channel and the
// stall/perf outputs. "master" is the fetch unit side, "slave" is the
// surrounding system (memory, WriteBack, Decode).
interface fetch_prefetch_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AWIDTH = 12
);
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              imem_req;
  logic [AWIDTH-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [XLEN-1:0]   imem_rdata;
  logic              fd_valid;
  logic [XLEN-1:0]   fd_pc;
  logic [XLEN-1:0]   fd_inst;
  logic              fd_ready;
  logic              stall_fetch;
  logic [31:0]       bubble_cnt;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, fd_ready,
    output imem_req, imem_addr, fd_valid, fd_pc, fd_inst, stall_fetch, bubble_cnt
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, fd_ready,
    input  imem_req, imem_addr, fd_valid, fd_pc, fd_inst, stall_fetch, bubble_cnt
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Prefetching instruction fetch stage.
// Issues word requests to instruction memory while queue occupancy plus
// in-flight requests stays below QDEPTH, tags returning words with their PC
// in an in-order queue and hands them to Decode over valid/ready.
// A WriteBack redirect flushes the queue and marks every in-flight request
// as stale so its response is dropped on return.
// Optional feature: define FETCH_BUBBLE_CNT_EN to build the bubble_cnt
// performance counter; otherwise bubble_cnt is tied to zero.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     AWIDTH       = 12,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     QDEPTH       = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  fetch_prefetch_unit_if.master bus
);

  localparam int unsigned     PW       = $clog2(QDEPTH);
  localparam logic [PW+1:0]   QDEPTH_W = (PW+2)'(QDEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(3);

  // PC of the next request to issue and PC of the next response to accept
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;

  // queue pointers carry one extra wrap bit to tell full from empty
  logic [PW:0] wptr_q, wptr_d;
  logic [PW:0] rptr_q, rptr_d;
  logic [PW:0] count;

  // requests granted but not yet answered, and how many of those are stale
  logic [PW:0] outst_q, outst_d;
  logic [PW:0] kill_q, kill_d;

  // holds requests off until the first clock after reset release
  logic run_q;

  logic [XLEN-1:0] pc_mem_q   [QDEPTH];
  logic [XLEN-1:0] inst_mem_q [QDEPTH];

  logic            req;
  logic            commit;
  logic            rsp;
  logic            push;
  logic            pop;
  logic            head_valid;
  logic [PW+1:0]   credit_used;
  logic [XLEN-1:0] redir_pc;

  assign count       = wptr_q - rptr_q;
  assign credit_used = {1'b0, count} + {1'b0, outst_q};
  assign req         = run_q && (credit_used < QDEPTH_W) && !bus.redirect_valid;
  assign commit      = req && bus.imem_gnt;
  // responses with nothing outstanding are protocol errors and are ignored
  assign rsp         = bus.imem_rvalid && (outst_q != '0);
  assign push        = rsp && (kill_q == '0) && !bus.redirect_valid;
  assign head_valid  = (wptr_q != rptr_q);
  assign pop         = head_valid && bus.fd_ready && !bus.redirect_valid;
  assign redir_pc    = bus.redirect_pc & PC_ALIGN;

  // next-state for PCs, queue pointers and request/kill accounting
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    kill_d     = kill_q;
    outst_d    = outst_q + (PW+1)'(commit) - (PW+1)'(rsp);

    if (bus.redirect_valid) begin
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      wptr_d     = '0;
      rptr_d     = '0;
      // every request still outstanding after this edge belongs to the old
      // stream, so the kill count becomes the updated outstanding count;
      // this is what accumulating over back-to-back redirects amounts to
      // while keeping kill_cnt <= outstanding
      kill_d     = outst_d;
    end else begin
      if (commit) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + PC_STEP;
        wptr_d    = wptr_q + (PW+1)'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + (PW+1)'(1);
      end
      if (rsp && (kill_q != '0)) begin
        kill_d = kill_q - (PW+1)'(1);
      end
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_VECTOR;
      resp_pc_q  <= RESET_VECTOR;
      wptr_q     <= '0;
      rptr_q     <= '0;
      outst_q    <= '0;
      kill_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      outst_q    <= outst_d;
      kill_q     <= kill_d;
      run_q      <= 1'b1;
    end
  end

  // queue storage; contents are only observed through a valid head
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wptr_q[PW-1:0]]   <= resp_pc_q;
      inst_mem_q[wptr_q[PW-1:0]] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q[AWIDTH+1:2];
  assign bus.fd_valid    = head_valid;
  assign bus.fd_pc       = head_valid ? pc_mem_q[rptr_q[PW-1:0]]   : '0;
  assign bus.fd_inst     = head_valid ? inst_mem_q[rptr_q[PW-1:0]] : '0;
  assign bus.stall_fetch = !head_valid;

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_q;

  // count cycles where Decode is ready but nothing is offered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
    end else if (bus.fd_ready && !head_valid && !bus.redirect_valid) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bus.bubble_cnt = bubble_q;
`else
  assign bus.bubble_cnt = '0;
`endif

endmodule
